// File: rtl/bcd_to_display_pkg.sv
// bcd_to_display_pkg: shared types, segment patterns and helpers for bcd_to_display (rev 1.0).
`default_nettype none

package bcd_to_display_pkg;

  localparam int BIN_W = 10;
  localparam int BCD_W = 12;
  localparam int SEG_W = 7;

  localparam logic [BIN_W-1:0] BCD_MAX = 10'd999;
  localparam logic [BCD_W-1:0] BCD_SAT = 12'h999;

  // Out-of-range nibble; the decoder turns it into a blank digit.
  localparam logic [3:0] NIB_BLANK = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Active-low patterns, bit0 = a ... bit6 = g.
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (res[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = res[4*i +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_to_display_seg7_decode.sv
// seg7_decode: one BCD nibble to seven segments, polarity set by SEG_ACTIVE_LOW (rev 1.0).
`default_nettype none

module seg7_decode
  import bcd_to_display_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg
);

  logic [SEG_W-1:0] seg_low;

  always_comb begin
    seg_low = SEG_BLANK;
    case (nibble)
      4'd0:    seg_low = SEG_0;
      4'd1:    seg_low = SEG_1;
      4'd2:    seg_low = SEG_2;
      4'd3:    seg_low = SEG_3;
      4'd4:    seg_low = SEG_4;
      4'd5:    seg_low = SEG_5;
      4'd6:    seg_low = SEG_6;
      4'd7:    seg_low = SEG_7;
      4'd8:    seg_low = SEG_8;
      4'd9:    seg_low = SEG_9;
      default: seg_low = SEG_BLANK;
    endcase
  end

  assign seg = SEG_ACTIVE_LOW ? seg_low : ~seg_low;

endmodule

`default_nettype wire

// File: rtl/bcd_to_display.sv
// bcd_to_display: sequential double-dabble binary-to-BCD with saturation and 3-digit 7-seg decode (rev 1.0).
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits on digito2/digito1.
`default_nettype none

module bcd_to_display
  import bcd_to_display_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BIN_W-1:0] valor_bin,
  output logic [BCD_W-1:0] valor_bcd,
  output logic [SEG_W-1:0] digito0,
  output logic [SEG_W-1:0] digito1,
  output logic [SEG_W-1:0] digito2,
  output logic             overflow,
  output logic             valid
);

  state_t           state;
  logic [BIN_W-1:0] bin_shift;
  logic [BCD_W-1:0] scratch;
  logic [BCD_W-1:0] scratch_adj;
  logic [3:0]       bit_cnt;
  logic             sat_pending;

  assign scratch_adj = add3_nibbles(scratch);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      bin_shift   <= '0;
      scratch     <= '0;
      bit_cnt     <= '0;
      sat_pending <= 1'b0;
      valor_bcd   <= '0;
      overflow    <= 1'b0;
      valid       <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Saturation is decided here because the thousands digit never fits the scratch.
          bin_shift   <= valor_bin;
          sat_pending <= (valor_bin > BCD_MAX);
          scratch     <= '0;
          bit_cnt     <= '0;
          state       <= ST_SHIFT;
        end
        ST_SHIFT: begin
          scratch   <= {scratch_adj[BCD_W-2:0], bin_shift[BIN_W-1]};
          bin_shift <= {bin_shift[BIN_W-2:0], 1'b0};
          bit_cnt   <= bit_cnt + 4'd1;
          if (bit_cnt == 4'(BIN_W - 1)) begin
            state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          valor_bcd <= sat_pending ? BCD_SAT : scratch;
          overflow  <= sat_pending;
          valid     <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic [3:0] nib0;
  logic [3:0] nib1;
  logic [3:0] nib2;

  assign nib0 = valor_bcd[3:0];
`ifdef LEADING_ZERO_BLANK_EN
  assign nib2 = (valor_bcd[11:8] == 4'd0) ? NIB_BLANK : valor_bcd[11:8];
  assign nib1 = (valor_bcd[11:4] == 8'd0) ? NIB_BLANK : valor_bcd[7:4];
`else
  assign nib2 = valor_bcd[11:8];
  assign nib1 = valor_bcd[7:4];
`endif

  seg7_decode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec0 (.nibble(nib0), .seg(digito0));
  seg7_decode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec1 (.nibble(nib1), .seg(digito1));
  seg7_decode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec2 (.nibble(nib2), .seg(digito2));

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_display.sv
// tb_bcd_to_display: directed self-checking bench for bcd_to_display (rev 1.0).
`default_nettype none

module tb_bcd_to_display;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = SB;
`else
  localparam logic [6:0] LZ = S0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] valor_bin = '0;
  logic [11:0] valor_bcd;
  logic [6:0] digito0;
  logic [6:0] digito1;
  logic [6:0] digito2;
  logic       overflow;
  logic       valid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bcd_to_display #(.SEG_ACTIVE_LOW(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .valor_bin (valor_bin),
    .valor_bcd (valor_bcd),
    .digito0   (digito0),
    .digito1   (digito1),
    .digito2   (digito2),
    .overflow  (overflow),
    .valid     (valid)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns cycles until valid and how often valor_bcd moved before it.
  task automatic wait_valid(output int cycles, output int changes);
    logic [11:0] prev;
    prev    = valor_bcd;
    cycles  = 0;
    changes = 0;
    do begin
      step();
      cycles++;
      if (!valid && (valor_bcd !== prev)) changes++;
    end while (!valid && cycles < 40);
    if (!valid) check_eq("valid_timeout", 32'(valid), 32'd1);
  endtask

  task automatic check_out(input string tag, input logic [11:0] bcd, input logic ovf,
                           input logic [6:0] d2, input logic [6:0] d1, input logic [6:0] d0);
    check_eq({tag, "_bcd"}, 32'(valor_bcd), 32'(bcd));
    check_eq({tag, "_ovf"}, 32'(overflow), 32'(ovf));
    check_eq({tag, "_d2"}, 32'(digito2), 32'(d2));
    check_eq({tag, "_d1"}, 32'(digito1), 32'(d1));
    check_eq({tag, "_d0"}, 32'(digito0), 32'(d0));
  endtask

  task automatic convert(input logic [9:0] v, input string tag, input logic [11:0] bcd,
                         input logic ovf, input logic [6:0] d2, input logic [6:0] d1,
                         input logic [6:0] d0);
    int n;
    int ch;
    valor_bin = v;
    wait_valid(n, ch);
    check_eq({tag, "_latency"}, 32'(n), 32'd12);
    check_eq({tag, "_stable"}, 32'(ch), 32'd0);
    check_out(tag, bcd, ovf, d2, d1, d0);
  endtask

  initial begin
    int n;
    int ch;
    int pulses;

    valor_bin = 10'd123;
    reset     = 1'b1;
    repeat (3) begin
      step();
      check_eq("rst_valid", 32'(valid), 32'd0);
      check_out("rst", 12'h000, 1'b0, LZ, LZ, S0);
    end
    reset = 1'b0;
    wait_valid(n, ch);
    check_eq("rst_release_latency", 32'(n), 32'd12);
    check_out("v123", 12'h123, 1'b0, S1, S2, S3);

    // Input moves from 5 to 870 two shift cycles into the conversion.
    valor_bin = 10'd5;
    repeat (3) step();
    valor_bin = 10'd870;
    wait_valid(n, ch);
    check_eq("v005_latency", 32'(n), 32'd9);
    check_eq("v005_stable", 32'(ch), 32'd0);
    check_out("v005", 12'h005, 1'b0, LZ, LZ, S5);
    wait_valid(n, ch);
    check_eq("v870_latency", 32'(n), 32'd12);
    check_eq("v870_stable", 32'(ch), 32'd0);
    check_out("v870", 12'h870, 1'b0, S8, S7, S0);

    convert(10'd999,  "v999",  12'h999, 1'b0, S9, S9, S9);
    convert(10'd1000, "v1000", 12'h999, 1'b1, S9, S9, S9);
    convert(10'd1023, "v1023", 12'h999, 1'b1, S9, S9, S9);

    // Reset five cycles into a conversion of 456.
    valor_bin = 10'd456;
    pulses    = 0;
    repeat (5) begin
      step();
      if (valid) pulses++;
    end
    reset = 1'b1;
    repeat (2) begin
      step();
      if (valid) pulses++;
    end
    check_eq("abort_no_valid", 32'(pulses), 32'd0);
    check_out("abort_rst", 12'h000, 1'b0, LZ, LZ, S0);
    reset = 1'b0;
    wait_valid(n, ch);
    check_eq("v456_latency", 32'(n), 32'd12);
    check_out("v456", 12'h456, 1'b0, S4, S5, S6);

    convert(10'd0, "v000", 12'h000, 1'b0, LZ, LZ, S0);
    convert(10'd64, "v064", 12'h064, 1'b0, LZ, S6, S4);

`ifdef LEADING_ZERO_BLANK_EN
    convert(10'd7,  "lz007", 12'h007, 1'b0, SB, SB, S7);
    convert(10'd40, "lz040", 12'h040, 1'b0, SB, S4, S0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed still running, expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
